// File: rtl/ui_red_acc_pkg.sv
// ui_red_acc_pkg: shared definitions for the ui_red_acc reduction accumulator.
//   - state_t  : FSM state encoding (ACC_S gathers elements, HOLD_S holds a result)
//   - clog2_f  : ceiling log2, used to size the element counter
package ui_red_acc_pkg;

  typedef enum logic {
    ACC_S  = 1'b0,
    HOLD_S = 1'b1
  } state_t;

  // Ceiling log2 for elaboration-time sizing; returns 0 for v <= 1.
  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ui_add_c.sv
// ui_add_c: combinational N-bit unsigned adder with carry-out.
// Ports:
//   a, b : N-bit unsigned operands
//   s    : N-bit sum (a + b modulo 2^N)
//   co   : carry-out of bit N-1
module ui_add_c #(
  parameter int N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] s,
  output logic         co
);

  // One extra bit on each operand captures the carry-out.
  assign {co, s} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/ui_red_acc.sv
// ui_red_acc: streaming unsigned reduction accumulator. Sums each group of LEN
// consecutive N-bit products modulo 2^N and presents the registered sum plus a
// sticky carry flag over a valid/ready handshake.
// Ports:
//   clk, rst  : clock and asynchronous active-high reset
//   in_data   : product from the multiplier
//   in_valid  : in_data valid this cycle
//   in_ready  : element accepted this cycle (combinational, depends on out_ready)
//   out_data  : completed reduction sum (registered)
//   out_valid : out_data/out_ovf valid (registered)
//   out_ready : consumer accepts result this cycle
//   out_ovf   : at least one carry-out occurred during this reduction (registered)
module ui_red_acc
  import ui_red_acc_pkg::*;
#(
  parameter int N   = 64,
  parameter int LEN = 16,
  parameter int CW  = (clog2_f(LEN) < 1) ? 1 : clog2_f(LEN)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_ovf
);

  localparam logic [CW-1:0] LAST_C = CW'(LEN - 1);

  state_t        state_r,     state_s;
  logic [N-1:0]  acc_r,       acc_s;
  logic          ovf_acc_r,   ovf_acc_s;
  logic [CW-1:0] cnt_r,       cnt_s;
  logic [N-1:0]  out_data_r,  out_data_s;
  logic          out_valid_r, out_valid_s;
  logic          out_ovf_r,   out_ovf_s;

  logic [N-1:0]  sum_s;
  logic          carry_s;
  logic          in_ready_s;
  logic          accept_s;
  logic          emit_s;
  logic          last_s;

  ui_add_c #(.N(N)) u_add (
    .a  (acc_r),
    .b  (in_data),
    .s  (sum_s),
    .co (carry_s)
  );

  // HOLD passes out_ready straight through so a consumed result frees the slot
  // in the same cycle; reset blocks acceptance.
  assign in_ready_s = rst ? 1'b0 : ((state_r == ACC_S) ? 1'b1 : out_ready);
  assign accept_s   = in_valid && in_ready_s;
  assign emit_s     = out_valid_r && out_ready;
  assign last_s     = (cnt_r == LAST_C);

  // Next-state and next-register computation for the ACC/HOLD FSM.
  always_comb begin
    state_s     = state_r;
    acc_s       = acc_r;
    ovf_acc_s   = ovf_acc_r;
    cnt_s       = cnt_r;
    out_data_s  = out_data_r;
    out_valid_s = out_valid_r;
    out_ovf_s   = out_ovf_r;
    case (state_r)
      ACC_S: begin
        if (accept_s) begin
          if (last_s) begin
            out_data_s  = sum_s;
            out_ovf_s   = ovf_acc_r | carry_s;
            out_valid_s = 1'b1;
            acc_s       = {N{1'b0}};
            ovf_acc_s   = 1'b0;
            cnt_s       = {CW{1'b0}};
            state_s     = HOLD_S;
          end else begin
            acc_s       = sum_s;
            ovf_acc_s   = ovf_acc_r | carry_s;
            cnt_s       = cnt_r + CW'(1);
          end
        end else begin
          state_s = ACC_S;
        end
      end
      HOLD_S: begin
        if (emit_s) begin
          if (accept_s) begin
            // Back-to-back: the accepted element opens the next reduction.
            if (LEN == 1) begin
              out_data_s  = in_data;
              out_ovf_s   = 1'b0;
              out_valid_s = 1'b1;
              state_s     = HOLD_S;
            end else begin
              acc_s       = in_data;
              cnt_s       = CW'(1);
              ovf_acc_s   = 1'b0;
              out_valid_s = 1'b0;
              state_s     = ACC_S;
            end
          end else begin
            out_valid_s = 1'b0;
            state_s     = ACC_S;
          end
        end else begin
          state_s = HOLD_S;
        end
      end
      default: begin
        state_s     = ACC_S;
        acc_s       = {N{1'b0}};
        ovf_acc_s   = 1'b0;
        cnt_s       = {CW{1'b0}};
        out_valid_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ACC_S;
      acc_r       <= {N{1'b0}};
      ovf_acc_r   <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      out_data_r  <= {N{1'b0}};
      out_valid_r <= 1'b0;
      out_ovf_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      ovf_acc_r   <= ovf_acc_s;
      cnt_r       <= cnt_s;
      out_data_r  <= out_data_s;
      out_valid_r <= out_valid_s;
      out_ovf_r   <= out_ovf_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_ui_red_acc.sv
// tb_ui_red_acc: scoreboard bench for ui_red_acc. Three instances (LEN = 4, 3, 1,
// N = 16) share clock and reset; stimulus pushes hand-computed results into a
// per-instance queue and a negedge monitor pops and compares on every emit.
module tb_ui_red_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data_a   [3];
  logic        in_valid_a  [3];
  logic        in_ready_a  [3];
  logic [15:0] out_data_a  [3];
  logic        out_valid_a [3];
  logic        out_ready_a [3];
  logic        out_ovf_a   [3];

  int vectors = 0;
  int errors  = 0;
  logic [16:0] q0[$];
  logic [16:0] q1[$];
  logic [16:0] q2[$];

  always #5 clk = ~clk;

  ui_red_acc #(.N(16), .LEN(4)) u0 (
    .clk(clk), .rst(rst), .in_data(in_data_a[0]), .in_valid(in_valid_a[0]),
    .in_ready(in_ready_a[0]), .out_data(out_data_a[0]), .out_valid(out_valid_a[0]),
    .out_ready(out_ready_a[0]), .out_ovf(out_ovf_a[0]));

  ui_red_acc #(.N(16), .LEN(3)) u1 (
    .clk(clk), .rst(rst), .in_data(in_data_a[1]), .in_valid(in_valid_a[1]),
    .in_ready(in_ready_a[1]), .out_data(out_data_a[1]), .out_valid(out_valid_a[1]),
    .out_ready(out_ready_a[1]), .out_ovf(out_ovf_a[1]));

  ui_red_acc #(.N(16), .LEN(1)) u2 (
    .clk(clk), .rst(rst), .in_data(in_data_a[2]), .in_valid(in_valid_a[2]),
    .in_ready(in_ready_a[2]), .out_data(out_data_a[2]), .out_valid(out_valid_a[2]),
    .out_ready(out_ready_a[2]), .out_ovf(out_ovf_a[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input logic ovf, input logic [15:0] d);
    case (k)
      0: q0.push_back({ovf, d});
      1: q1.push_back({ovf, d});
      default: q2.push_back({ovf, d});
    endcase
  endtask

  task automatic mon_pop(input int k);
    logic [16:0] e;
    logic        got;
    got = 1'b0;
    e   = 17'd0;
    case (k)
      0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
    endcase
    vectors++;
    if (!got) begin
      errors++;
      $display("FAIL unexpected_result dut%0d: got ovf=%0b data=%0h, expected no result at %0t",
               k, out_ovf_a[k], out_data_a[k], $time);
    end else if ({out_ovf_a[k], out_data_a[k]} !== e) begin
      errors++;
      $display("FAIL result dut%0d: got ovf=%0b data=%0h, expected ovf=%0b data=%0h at %0t",
               k, out_ovf_a[k], out_data_a[k], e[16], e[15:0], $time);
    end
  endtask

  // Monitor: every emit event is compared against the head of that instance's queue.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (out_valid_a[k] && out_ready_a[k]) begin
          mon_pop(k);
        end
      end
    end
  end

  // Present one element and hold it until accepted; returns just after the accepting edge
  // with in_valid still high. chk_rdy demands acceptance on the first cycle.
  task automatic send(input int k, input logic [15:0] d, input bit chk_rdy);
    int budget;
    budget = 0;
    in_data_a[k]  = d;
    in_valid_a[k] = 1'b1;
    @(negedge clk);
    if (chk_rdy) check($sformatf("in_ready_dut%0d", k), 32'(in_ready_a[k]), 32'd1);
    while (!in_ready_a[k] && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready_a[k]) begin
      vectors++;
      errors++;
      $display("FAIL accept_timeout dut%0d: got in_ready=0, expected 1 within 50 cycles", k);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    in_valid_a[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data_a[k]   = 16'd0;
      in_valid_a[k]  = 1'b0;
      out_ready_a[k] = 1'b1;
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_out_valid_dut%0d", k), 32'(out_valid_a[k]), 32'd0);
      check($sformatf("rst_out_data_dut%0d", k), 32'(out_data_a[k]), 32'd0);
      check($sformatf("rst_out_ovf_dut%0d", k), 32'(out_ovf_a[k]), 32'd0);
      check($sformatf("rst_in_ready_dut%0d", k), 32'(in_ready_a[k]), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // LEN=4 continuous stream 1,2,3,4 -> 10, in_ready never drops.
    push(0, 1'b0, 16'd10);
    send(0, 16'd1, 1'b1);
    send(0, 16'd2, 1'b1);
    send(0, 16'd3, 1'b1);
    send(0, 16'd4, 1'b1);
    // Overflow reduction, then a clean one to show the flag does not leak.
    push(0, 1'b1, 16'h0001);
    send(0, 16'hFFFF, 1'b1);
    send(0, 16'd2, 1'b1);
    send(0, 16'd0, 1'b1);
    send(0, 16'd0, 1'b1);
    push(0, 1'b0, 16'd4);
    for (int i = 0; i < 4; i++) send(0, 16'd1, 1'b1);
    idle(0);
    repeat (2) @(posedge clk);
    #1;

    // LEN=4 with random gaps: 5,5,5,5 -> 20.
    push(0, 1'b0, 16'd20);
    for (int i = 0; i < 4; i++) begin
      send(0, 16'd5, 1'b0);
      idle(0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;

    // LEN=3 held result: out_ready low for 5 cycles, then back-to-back accept.
    out_ready_a[1] = 1'b0;
    push(1, 1'b0, 16'd6);
    send(1, 16'd1, 1'b1);
    send(1, 16'd2, 1'b1);
    send(1, 16'd3, 1'b1);
    in_data_a[1] = 16'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_in_ready", 32'(in_ready_a[1]), 32'd0);
      check("hold_out_valid", 32'(out_valid_a[1]), 32'd1);
      check("hold_out_data", 32'(out_data_a[1]), 32'd6);
    end
    @(posedge clk);
    #1;
    out_ready_a[1] = 1'b1;
    send(1, 16'd7, 1'b1);
    send(1, 16'd8, 1'b1);
    push(1, 1'b0, 16'd24);
    send(1, 16'd9, 1'b1);
    idle(1);
    repeat (2) @(posedge clk);
    #1;

    // LEN=1: each element is its own result, out_valid stays high.
    push(2, 1'b0, 16'd7);
    send(2, 16'd7, 1'b1);
    push(2, 1'b0, 16'd8);
    send(2, 16'd8, 1'b1);
    push(2, 1'b0, 16'd9);
    send(2, 16'd9, 1'b1);
    idle(2);
    repeat (2) @(posedge clk);
    #1;

    // Reset discards a pending result (dut1) and a partial reduction (dut0).
    out_ready_a[1] = 1'b0;
    for (int i = 0; i < 3; i++) send(1, 16'd1, 1'b0);
    idle(1);
    send(0, 16'd10, 1'b0);
    send(0, 16'd20, 1'b0);
    idle(0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid0", 32'(out_valid_a[0]), 32'd0);
    check("mid_rst_out_data0", 32'(out_data_a[0]), 32'd0);
    check("mid_rst_out_ovf0", 32'(out_ovf_a[0]), 32'd0);
    check("mid_rst_out_valid1", 32'(out_valid_a[1]), 32'd0);
    check("mid_rst_out_data1", 32'(out_data_a[1]), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready_a[1] = 1'b1;
    push(0, 1'b0, 16'd4);
    for (int i = 0; i < 4; i++) send(0, 16'd1, 1'b1);
    idle(0);
    push(1, 1'b0, 16'd6);
    for (int i = 0; i < 3; i++) send(1, 16'd2, 1'b1);
    idle(1);

    repeat (4) @(posedge clk);
    #1;
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q2_drained", 32'(q2.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
